// File: rtl/fifo_rr_drain_arbiter.sv
// Round-robin drain of NUM_SRC source FIFOs into one registered valid/ready
// output stage, taking at most BURST_MAX beats per grant.
module fifo_rr_drain_arbiter #(
  parameter int NUM_SRC   = 4,
  parameter int DATA_W    = 32,
  parameter int IDX_W     = 2,
  parameter int BURST_MAX = 4,
  parameter int BURST_W   = 3
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic                      CLR,
  input  logic [NUM_SRC-1:0]        SRC_EMPTY_N,
  input  logic [NUM_SRC*DATA_W-1:0] SRC_D_OUT,
  output logic [NUM_SRC-1:0]        SRC_DEQ,
  output logic                      OUT_VALID,
  output logic [DATA_W-1:0]         OUT_DATA,
  output logic [IDX_W-1:0]          OUT_SRC,
  input  logic                      OUT_RDY
);

  typedef enum logic {IDLE, BURST} state_t;

  localparam logic [IDX_W:0]     NUM_SRC_X = (IDX_W+1)'(NUM_SRC);
  localparam logic [IDX_W-1:0]   LAST_IDX  = IDX_W'(NUM_SRC-1);
  localparam logic [BURST_W-1:0] LAST_BEAT = BURST_W'(BURST_MAX-1);

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [IDX_W-1:0]   grant_q, grant_d;
  logic [BURST_W-1:0] burst_cnt_q, burst_cnt_d;
  logic               out_valid_q, out_valid_d;
  logic [DATA_W-1:0]  out_data_q, out_data_d;
  logic [IDX_W-1:0]   out_src_q, out_src_d;

  logic               pick_found;
  logic [IDX_W-1:0]   pick_idx;
  logic [IDX_W:0]     scan_idx;
  logic               grant_ready;
  logic               can_load;
  logic               deq;
  logic [IDX_W-1:0]   grant_next;

  // Scan downwards so the candidate closest to rr_ptr is the last one written.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    scan_idx   = '0;
    for (int k = NUM_SRC-1; k >= 0; k--) begin
      scan_idx = {1'b0, rr_ptr_q} + (IDX_W+1)'(k);
      if (scan_idx >= NUM_SRC_X) scan_idx = scan_idx - NUM_SRC_X;
      if (SRC_EMPTY_N[scan_idx[IDX_W-1:0]]) begin
        pick_found = 1'b1;
        pick_idx   = scan_idx[IDX_W-1:0];
      end
    end
  end

  assign grant_ready = SRC_EMPTY_N[grant_q];
  assign can_load    = !out_valid_q || OUT_RDY;
  assign deq         = (state_q == BURST) && grant_ready && can_load && !CLR && !RST;
  assign grant_next  = (grant_q == LAST_IDX) ? '0 : grant_q + 1'b1;

  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    grant_d     = grant_q;
    burst_cnt_d = burst_cnt_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_src_d   = out_src_q;
    SRC_DEQ     = '0;
    if (deq) SRC_DEQ[grant_q] = 1'b1;

    case (state_q)
      IDLE: begin
        if (pick_found) begin
          state_d     = BURST;
          grant_d     = pick_idx;
          burst_cnt_d = '0;
        end
      end
      BURST: begin
        if (!grant_ready) begin
          state_d  = IDLE;
          rr_ptr_d = grant_next;
        end else if (deq) begin
          burst_cnt_d = burst_cnt_q + 1'b1;
          if (burst_cnt_q == LAST_BEAT) begin
            state_d  = IDLE;
            rr_ptr_d = grant_next;
          end
        end
      end
    endcase

    if (deq) begin
      out_valid_d = 1'b1;
      out_data_d  = SRC_D_OUT[grant_q*DATA_W +: DATA_W];
      out_src_d   = grant_q;
    end else if (out_valid_q && OUT_RDY) begin
      out_valid_d = 1'b0;
    end

    if (CLR) begin
      state_d     = IDLE;
      rr_ptr_d    = '0;
      burst_cnt_d = '0;
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= IDLE;
      rr_ptr_q    <= '0;
      grant_q     <= '0;
      burst_cnt_q <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_src_q   <= '0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      grant_q     <= grant_d;
      burst_cnt_q <= burst_cnt_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_src_q   <= out_src_d;
    end
  end

  assign OUT_VALID = out_valid_q;
  assign OUT_DATA  = out_data_q;
  assign OUT_SRC   = out_src_q;

  // Dequeue strobe must be one-hot-or-zero and only towards a non-empty source.
  assert property (@(posedge CLK) disable iff (RST) $onehot0(SRC_DEQ));
  assert property (@(posedge CLK) disable iff (RST) (SRC_DEQ & ~SRC_EMPTY_N) == '0);

endmodule
